// File: rtl/uart_pkg.sv
// Shared types for the configurable UART transmitter.
// Parity modes, serialiser states and config decode helpers.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  localparam logic [1:0] PAR_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } tx_state_e;

  function automatic parity_e cfg_to_parity(
    input logic [1:0] c
  );
    if (c == PAR_RSVD) begin
      return PAR_NONE;
    end
    return parity_e'(c);
  endfunction

endpackage

// File: rtl/uart_baud_div.sv
// Bit-period divider for the UART transmitter.
// Counts 0..BAUD_DIV-1 while enabled; bit_end marks the last count.
`timescale 1ns/1ps
module uart_baud_div #(
  parameter int BAUD_DIV = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic bit_end
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_end = en && (cnt_q == LAST);

  // next count: clear wins, wrap at the end of each bit
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO buffering words ahead of the serialiser.
// Pointers carry a wrap bit so full and empty are unambiguous.
`timescale 1ns/1ps
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wp_q;
  logic [AW:0]      wp_d;
  logic [AW:0]      rp_q;
  logic [AW:0]      rp_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wp_q == rp_q);
  assign full    = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rp_q[AW-1:0]];

  // pointer advance on accepted push/pop
  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (do_push) begin
      wp_d = wp_q + 1'b1;
    end
    if (do_pop) begin
      rp_d = rp_q + 1'b1;
    end
  end

  // pointer registers; reset flushes the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // storage needs no reset: empty pointers hide stale data
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wp_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: width, divider, parity, stop bits.
// Define UART_TX_FIFO_EN to add an input FIFO of FIFO_DEPTH words.
`timescale 1ns/1ps
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (BAUD_DIV < 2) begin : g_bad_div
    $error("uart_tx_cfg: BAUD_DIV must be >= 2");
  end
  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2, >= 2");
  end

  tx_state_e            state_q;
  tx_state_e            state_d;
  logic [IW-1:0]        idx_q;
  logic [IW-1:0]        idx_d;
  logic [DATA_BITS-1:0] sr_q;
  logic [DATA_BITS-1:0] sr_d;
  logic                 par_en_q;
  logic                 par_en_d;
  logic                 par_val_q;
  logic                 par_val_d;
  logic                 stop2_q;
  logic                 stop2_d;
  logic                 txd_q;
  logic                 txd_d;

  logic                 bit_end;
  logic                 last_stop;
  logic                 idle;
  logic                 start;
  logic [DATA_BITS-1:0] src_data;
  parity_e              src_par;

  assign idle      = (state_q == IDLE);
  assign last_stop = bit_end &&
                     ((state_q == STOP1 && !stop2_q) ||
                      (state_q == STOP2));
  assign src_par   = cfg_to_parity(cfg_parity);
  assign txd       = txd_q;
  assign tx_done   = last_stop;

`ifdef UART_TX_FIFO_EN
  logic f_full;
  logic f_empty;

  assign start    = (idle || last_stop) && !f_empty;
  assign tx_ready = !f_full;
  assign busy     = !idle || !f_empty;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_valid),
    .wdata (tx_data),
    .pop   (start),
    .rdata (src_data),
    .full  (f_full),
    .empty (f_empty)
  );
`else
  assign tx_ready = idle || last_stop;
  assign start    = tx_valid && tx_ready;
  assign busy     = !idle;
  assign src_data = tx_data;
`endif

  uart_baud_div #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start),
    .en      (!idle),
    .bit_end (bit_end)
  );

  // frame sequencing; a new frame start overrides end-of-frame
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sr_d      = sr_q;
    par_en_d  = par_en_q;
    par_val_d = par_val_q;
    stop2_d   = stop2_q;
    txd_d     = txd_q;
    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          txd_d   = sr_q[0];
          sr_d    = sr_q >> 1;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
            state_d = par_en_q ? PARITY : STOP1;
            txd_d   = par_en_q ? par_val_q : 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
            txd_d = sr_q[0];
            sr_d  = sr_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP1;
          txd_d   = 1'b1;
        end
      end
      STOP1: begin
        if (bit_end && stop2_q) begin
          state_d = STOP2;
          txd_d   = 1'b1;
        end
      end
      STOP2: begin
        txd_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
    if (last_stop) begin
      state_d = IDLE;
      txd_d   = 1'b1;
    end
    if (start) begin
      state_d   = START;
      idx_d     = '0;
      txd_d     = 1'b0;
      sr_d      = src_data;
      par_en_d  = (src_par != PAR_NONE);
      par_val_d = (^src_data) ^ (src_par == PAR_ODD);
      stop2_d   = cfg_stop2;
    end
  end

  // serialiser registers; reset drives the line idle at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      sr_q      <= '0;
      par_en_q  <= 1'b0;
      par_val_q <= 1'b0;
      stop2_q   <= 1'b0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sr_q      <= sr_d;
      par_en_q  <= par_en_d;
      par_val_q <= par_val_d;
      stop2_q   <= stop2_d;
      txd_q     <= txd_d;
    end
  end

endmodule
